// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned INSTR_W     = 32;
   localparam int unsigned INSTR_BYTES = 4;
   localparam int unsigned ALIGN_W     = $clog2(INSTR_BYTES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } fetch_state_t;

   // Decode-facing payload for the default 32-bit configuration.
   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a registered head entry and a flush.
// Push while full is accepted only when a pop happens in the same cycle.
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       push_data_i,
   input  logic                   pop_i,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   valid_o,
   output logic [WIDTH-1:0]       head_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             full_c;
   logic             do_pop_c;
   logic             do_push_c;

   assign full_c    = (cnt_q == CNT_W'(DEPTH));
   assign do_pop_c  = pop_i && valid_q && !flush_i;
   assign do_push_c = push_i && !flush_i && (!full_c || do_pop_c);

   // Next pointers, occupancy and the value the head register will hold.
   always_comb begin
      wr_d   = wr_q;
      rd_d   = rd_q;
      cnt_d  = cnt_q;
      head_d = head_q;
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push_c) wr_d = wr_q + PTR_W'(1);
         if (do_pop_c)  rd_d = rd_q + PTR_W'(1);
         case ({do_push_c, do_pop_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
         // The head mirrors mem_q[rd]; refresh it whenever the head slot changes.
         if (do_pop_c) begin
            if (cnt_q > CNT_W'(1))  head_d = mem_q[rd_q + PTR_W'(1)];
            else if (do_push_c)     head_d = push_data_i;
         end else if ((cnt_q == '0) && do_push_c) begin
            head_d = push_data_i;
         end
      end
      valid_d = (cnt_d != '0);
   end

   // Control and head registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         head_q  <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         head_q  <= head_d;
      end
   end

   // Entry storage; contents are only meaningful below the count.
   always_ff @(posedge clk) begin
      if (do_push_c) mem_q[wr_q] <= push_data_i;
   end

   assign count_o = cnt_q;
   assign valid_o = valid_q;
   assign head_o  = head_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, reads the async ROM and
// queues {pc, instr} for decode. Handles redirects and misaligned targets.
module instr_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned              ADDRESS_WIDTH = 32,
   parameter int unsigned              INSTR_WIDTH   = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0,
   parameter int unsigned              BUF_DEPTH     = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     fetch_en,
   output logic [ADDRESS_WIDTH-1:0] rom_addr,
   input  logic [INSTR_WIDTH-1:0]   rom_data,
   input  logic                     redirect_valid,
   input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [INSTR_WIDTH-1:0]   out_instr,
   output logic [ADDRESS_WIDTH-1:0] out_pc,
   output logic                     misalign_err
);

   localparam int unsigned ENTRY_W = ADDRESS_WIDTH + INSTR_WIDTH;
   localparam int unsigned CNT_W   = $clog2(BUF_DEPTH) + 1;

   typedef struct packed {
      logic [ADDRESS_WIDTH-1:0] pc;
      logic [INSTR_WIDTH-1:0]   instr;
   } entry_t;

   fetch_state_t             state_q;
   logic [ADDRESS_WIDTH-1:0] pc_q;
   logic                     err_q;

   logic [CNT_W-1:0] fifo_count;
   logic             fifo_valid;
   entry_t           push_entry;
   entry_t           head_entry;
   logic             flush_c;
   logic             pop_c;
   logic             push_c;
   logic             misalign_c;

   // A redirect is honoured everywhere except HALT and always empties the buffer.
   assign flush_c    = redirect_valid && (state_q != HALT);
   assign misalign_c = (redirect_pc[ALIGN_W-1:0] != '0);
   assign pop_c      = fifo_valid && out_ready && !flush_c;
   assign push_c     = (state_q == FETCH) && fetch_en && !redirect_valid &&
                       ((fifo_count != CNT_W'(BUF_DEPTH)) || pop_c);
   assign push_entry = {pc_q, rom_data};

   // Fetch FSM, PC sequencing and the sticky misalignment fault.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_VECTOR;
         err_q   <= 1'b0;
      end else if (flush_c) begin
         if (misalign_c) begin
            err_q   <= 1'b1;
            state_q <= HALT;
         end else begin
            pc_q <= redirect_pc;
         end
      end else begin
         case (state_q)
            IDLE:    if (fetch_en)  state_q <= FETCH;
            FETCH:   if (!fetch_en) state_q <= IDLE;
            default: state_q <= state_q;
         endcase
         if (push_c) pc_q <= pc_q + ADDRESS_WIDTH'(INSTR_BYTES);
      end
   end

   fetch_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush_c),
      .push_i      (push_c),
      .push_data_i (push_entry),
      .pop_i       (pop_c),
      .count_o     (fifo_count),
      .valid_o     (fifo_valid),
      .head_o      (head_entry)
   );

   assign rom_addr     = pc_q;
   assign out_valid    = fifo_valid;
   assign out_pc       = head_entry.pc;
   assign out_instr    = head_entry.instr;
   assign misalign_err = err_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: directed phases push expected
// {pc, instr} entries; monitors pop and compare on every accepted output.
module tb_instr_fetch_ctrl;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        fetch_en;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        misalign_err;

   logic        fetch_en_w;
   logic        out_ready_w;
   logic [31:0] rom_addr_w;
   logic [31:0] rom_data_w;
   logic        out_valid_w;
   logic [31:0] out_instr_w;
   logic [31:0] out_pc_w;
   logic        misalign_err_w;

   exp_t exp_q[$];
   exp_t exp_w_q[$];
   int   n_cmp;
   int   n_err;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return 32'h1000_0000 + {2'b00, a[31:2]};
   endfunction

   assign rom_data   = rom_word(rom_addr);
   assign rom_data_w = rom_word(rom_addr_w);

   instr_fetch_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .misalign_err   (misalign_err)
   );

   instr_fetch_ctrl #(
      .RESET_VECTOR (32'hFFFF_FFF8)
   ) dut_w (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en_w),
      .rom_addr       (rom_addr_w),
      .rom_data       (rom_data_w),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .out_valid      (out_valid_w),
      .out_ready      (out_ready_w),
      .out_instr      (out_instr_w),
      .out_pc         (out_pc_w),
      .misalign_err   (misalign_err_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_main(input logic [31:0] pc);
      exp_t e;
      e.pc    = pc;
      e.instr = rom_word(pc);
      exp_q.push_back(e);
   endtask

   task automatic expect_wrap(input logic [31:0] pc);
      exp_t e;
      e.pc    = pc;
      e.instr = rom_word(pc);
      exp_w_q.push_back(e);
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      fetch_en       = 1'b0;
      fetch_en_w     = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      tick(2);
      rst_n = 1'b1;
   endtask

   // Main-DUT monitor: every accepted output must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL sb_extra: got pc %h required no output", out_pc);
            end else begin
               e = exp_q.pop_front();
               chk("sb_pc", out_pc, e.pc);
               chk("sb_instr", out_instr, e.instr);
            end
         end
      end
   end

   // Wrap-DUT monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid_w && out_ready_w) begin
            if (exp_w_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL sbw_extra: got pc %h required no output", out_pc_w);
            end else begin
               e = exp_w_q.pop_front();
               chk("sbw_pc", out_pc_w, e.pc);
               chk("sbw_instr", out_instr_w, e.instr);
            end
         end
      end
   end

   initial begin
      n_cmp          = 0;
      n_err          = 0;
      rst_n          = 1'b1;
      fetch_en       = 1'b0;
      fetch_en_w     = 1'b0;
      out_ready      = 1'b0;
      out_ready_w    = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      #1 rst_n = 1'b0;
      tick(2);

      // Reset values
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_instr", out_instr, 32'h0);
      chk("rst_err", 32'(misalign_err), 32'd0);
      chk("rst_addr", rom_addr, 32'h0);
      chk("rst_addr_w", rom_addr_w, 32'hFFFF_FFF8);
      chk("rst_valid_w", 32'(out_valid_w), 32'd0);

      // Streaming from reset, plus the wrapping reset vector on the second DUT
      rst_n = 1'b1;
      fetch_en   = 1'b1;
      out_ready  = 1'b1;
      fetch_en_w = 1'b1;
      expect_main(32'h00); expect_main(32'h04); expect_main(32'h08);
      expect_main(32'h0C); expect_main(32'h10);
      expect_wrap(32'hFFFF_FFF8); expect_wrap(32'hFFFF_FFFC); expect_wrap(32'h0000_0000);
      tick(1);
      chk("lat1_valid", 32'(out_valid), 32'd0);
      chk("lat1_valid_w", 32'(out_valid_w), 32'd0);
      tick(1);
      chk("lat2_valid", 32'(out_valid), 32'd1);
      chk("lat2_valid_w", 32'(out_valid_w), 32'd1);
      tick(2);
      fetch_en_w = 1'b0;
      tick(2);
      fetch_en = 1'b0;
      tick(2);
      chk("stream_end_valid", 32'(out_valid), 32'd0);
      chk("stream_end_addr", rom_addr, 32'h14);
      chk("wrap_end_addr", rom_addr_w, 32'h4);
      chk("wrap_end_valid", 32'(out_valid_w), 32'd0);

      // Backpressure: buffer fills, PC stalls, then drains in order
      do_reset();
      fetch_en  = 1'b1;
      out_ready = 1'b0;
      expect_main(32'h00); expect_main(32'h04); expect_main(32'h08);
      tick(5);
      chk("stall_addr", rom_addr, 32'h08);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_head_pc", out_pc, 32'h00);
      out_ready = 1'b1;
      tick(1);
      fetch_en = 1'b0;
      tick(3);
      chk("drain_valid", 32'(out_valid), 32'd0);
      chk("drain_addr", rom_addr, 32'h0C);

      // Redirect with a full buffer: stale entries must vanish
      do_reset();
      fetch_en  = 1'b1;
      out_ready = 1'b0;
      expect_main(32'h40); expect_main(32'h44);
      tick(4);
      chk("pre_redir_valid", 32'(out_valid), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      tick(1);
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      chk("redir_flush_valid", 32'(out_valid), 32'd0);
      chk("redir_addr", rom_addr, 32'h40);
      tick(2);
      fetch_en = 1'b0;
      tick(2);
      chk("redir_end_valid", 32'(out_valid), 32'd0);
      chk("redir_end_addr", rom_addr, 32'h48);

      // Misaligned redirect from IDLE: sticky fault, HALT ignores everything
      fetch_en       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h42;
      tick(1);
      redirect_valid = 1'b0;
      chk("mis_err", 32'(misalign_err), 32'd1);
      chk("mis_addr", rom_addr, 32'h48);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("halt_valid", 32'(out_valid), 32'd0);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h80;
      tick(1);
      redirect_valid = 1'b0;
      chk("halt_redir_addr", rom_addr, 32'h48);
      chk("halt_err_sticky", 32'(misalign_err), 32'd1);

      // Asynchronous reset between edges clears the fault immediately
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_err", 32'(misalign_err), 32'd0);
      chk("async_addr", rom_addr, 32'h0);

      // Stream, then async reset mid-stream, then restart from the reset vector
      out_ready = 1'b1;
      fetch_en  = 1'b1;
      expect_main(32'h00); expect_main(32'h04);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick(4);
      chk("mid_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_addr", rom_addr, 32'h0);
      chk("mid_rst_pc", out_pc, 32'h0);
      expect_main(32'h00); expect_main(32'h04); expect_main(32'h08);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick(4);
      fetch_en = 1'b0;
      tick(3);
      chk("restart_valid", 32'(out_valid), 32'd0);
      chk("restart_addr", rom_addr, 32'h0C);

      // Every expected entry must have been delivered
      chk("sb_left", 32'(exp_q.size()), 32'd0);
      chk("sbw_left", 32'(exp_w_q.size()), 32'd0);
      chk("wrap_err", 32'(misalign_err_w), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Sequences the byte-addressed, asynchronous-read instruction ROM for the single-cycle/pipelined RV32I core. Holds the PC and drives the ROM address once per cycle. Captures the combinational 32-bit instruction word into a small fetch buffer and presents {pc, instr} to decode through a valid/ready handshake. Handles branch/jump redirects, flushes, and misaligned-target faults.

Parameters:
ADDRESS_WIDTH, 32, width of PC and ROM address.
INSTR_WIDTH, 32, instruction word width (4 ROM bytes).
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
BUF_DEPTH, 2, fetch buffer entries (power of two, ≥2).

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
fetch_en  in  1  level; start/continue fetching.
rom_addr  out  ADDRESS_WIDTH  byte address to ROM (word-aligned).
rom_data  in  INSTR_WIDTH  combinational ROM read data for rom_addr.
redirect_valid  in  1  one-cycle pulse: flush and jump.
redirect_pc  in  ADDRESS_WIDTH  redirect target.
out_valid  out  1  buffer head valid.
out_ready  in  1  decode accepts head.
out_instr  out  INSTR_WIDTH  head instruction.
out_pc  out  ADDRESS_WIDTH  head PC.
misalign_err  out  1  sticky fault: redirect target not 4-byte aligned.

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE, pc=RESET_VECTOR, buffer empty, out_valid=0, out_instr=0, out_pc=0, misalign_err=0, rom_addr=RESET_VECTOR.
- rom_addr = pc at all times (combinational from pc register).
- States: IDLE, FETCH, HALT.
  IDLE -> FETCH when fetch_en=1 (no fetch that cycle).
  FETCH -> IDLE when fetch_en=0 (buffer contents retained, still drainable).
  any -> HALT on misaligned redirect; HALT exits only by reset.
- Enqueue condition (push): state==FETCH, fetch_en=1, no redirect_valid, and (count<BUF_DEPTH or pop this cycle). On push: entry={pc, rom_data}, pc<=pc+4 (wraps mod 2^ADDRESS_WIDTH, e.g. 0xFFFF_FFFC -> 0x0000_0000).
- Pop: out_valid & out_ready. out_valid = (count!=0); head is registered, so latency from fetch start to first out_valid = 2 cycles after fetch_en rises in IDLE, 1 cycle in FETCH.
- Full + pop same cycle: push allowed, count unchanged. Empty: pop impossible, out_instr/out_pc hold last value (don't-care to decode).
- Redirect (redirect_valid=1) in any state except HALT: buffer flushed (count<=0, out_valid=0 next cycle), concurrent pop ignored, no push. If redirect_pc[1:0]==0: pc<=redirect_pc, state unchanged. Else: misalign_err<=1, state<=HALT, pc unchanged.
- HALT: no push; pops still allowed (buffer already flushed, so out_valid=0).
- Redirect while in IDLE: pc updated, stays IDLE.
- Reset mid-operation: everything returns to reset values immediately, regardless of clock.
- Throughput: one instruction per cycle sustained when out_ready=1.

Decomposition:
- Package fetch_pkg: typedef enum logic [1:0] {IDLE, FETCH, HALT} fetch_state_t; localparam INSTR_BYTES=4; typedef struct packed {pc, instr} fetch_entry_t.
- Sub-module fetch_fifo: parameterised synchronous FIFO (BUF_DEPTH, entry width), push/pop/flush, count, async active-low reset; simultaneous push+pop when full permitted.

Test Plan:
- Reset, ROM word i = 0x1000_0000+i, fetch_en=1, out_ready=1 -> out_pc 0x0,0x4,0x8… on consecutive cycles, out_instr 0x1000_0000,0x1000_0001…, first out_valid 2 cycles after fetch_en.
- out_ready=0 for 5 cycles -> buffer fills to 2, pc stalls at 0x8, rom_addr=0x8; release -> 0x0,0x4,0x8 delivered in order, no loss/duplication.
- redirect_valid with redirect_pc=0x40 while buffer holds 2 entries -> next cycle out_valid=0, then out_pc=0x40,0x44; no stale 0x0/0x4 delivered.
- redirect_pc=0x42 -> misalign_err=1 next cycle, state HALT, out_valid stays 0 for 10 cycles despite fetch_en=1.
- RESET_VECTOR=0xFFFF_FFF8 -> out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
- Assert rst_n=0 mid-stream between clock edges -> out_valid, misalign_err drop immediately, rom_addr=RESET_VECTOR; after release fetch restarts from RESET_VECTOR.
